// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter owner for the MIPS fetch path. Selects the
//               next PC from PC+4, branch, J-type and JR targets, arbitrates
//               simultaneous redirects, inserts flush bubbles after a
//               redirect, halts on a misaligned JR and counts redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    // Bubble cycles after an accepted redirect, legal range 1..7.
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        branch_en,
    input  logic [15:0] branch_offset,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        misaligned,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Flush counter is loaded with FLUSH_CYCLES-1 so that FLUSH lasts
    // exactly FLUSH_CYCLES cycles (it leaves when the counter reads zero).
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] redirect_count_q, redirect_count_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        pc_valid_q;
    logic        flush_q;
    logic        misaligned_q;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] redirect_target;
    logic        redirect_req;
    logic        jr_fault;
    logic [15:0] count_inc;

    // Candidate targets and the priority-selected redirect (jr > jump > branch).
    always_comb begin
        pc4             = pc_q + 32'd4;
        jump_target     = {pc4[31:28], jump_index, 2'b00};
        branch_target   = pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        redirect_req    = jr_en | jump_en | branch_en;
        jr_fault        = jr_en && (jr_target[1:0] != 2'b00);
        if (jr_en) begin
            redirect_target = jr_target;
        end else if (jump_en) begin
            redirect_target = jump_target;
        end else begin
            redirect_target = branch_target;
        end
        count_inc = (redirect_count_q == COUNT_MAX) ? redirect_count_q
                                                    : redirect_count_q + 16'd1;
    end

    // Next-state logic; every register keeps its value unless a rule moves it.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        redirect_count_d = redirect_count_q;
        flush_cnt_d      = flush_cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (jr_fault) begin
                    // PC stays on the faulting JR so software can inspect it.
                    state_d = ST_HALT;
                end else if (redirect_req) begin
                    // A redirect is taken even while stalled.
                    pc_d             = redirect_target;
                    redirect_count_d = count_inc;
                    flush_cnt_d      = FLUSH_INIT;
                    state_d          = ST_FLUSH;
                end else if (!stall) begin
                    pc_d = pc4;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC, counters and status outputs, all registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_BOOT;
            pc_q             <= RESET_PC;
            redirect_count_q <= 16'd0;
            flush_cnt_q      <= 3'd0;
            pc_valid_q       <= 1'b0;
            flush_q          <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            redirect_count_q <= redirect_count_d;
            flush_cnt_q      <= flush_cnt_d;
            pc_valid_q       <= (state_d == ST_RUN);
            flush_q          <= (state_d == ST_FLUSH);
            misaligned_q     <= (state_d == ST_HALT);
        end
    end

    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
    assign flush          = flush_q;
    assign misaligned     = misaligned_q;
    assign redirect_count = redirect_count_q;

endmodule
`default_nettype wire
